// File: rtl/redun_mont_seq.sv
// Job sequencer for one VDF squaring run on the redun_mont datapath: flush, load once,
// count the self-iterated squarings, capture the t-th result, flush again.
module redun_mont_seq #(
    parameter int RST_CYC  = 4,
    parameter int WDOG_CYC = 1024,
    parameter int T_LEN    = 32,
    parameter int SQ_W     = 64
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [SQ_W-1:0]  i_sq,
    input  logic [T_LEN-1:0] i_t,
    input  logic             i_abort,
    output logic             o_busy,
    output logic [SQ_W-1:0]  o_res,
    output logic             o_res_val,
    output logic             o_err,
    output logic [T_LEN-1:0] o_cnt,
    output logic             o_dp_rst,
    output logic [SQ_W-1:0]  o_dp_sq,
    output logic             o_dp_val,
    input  logic [SQ_W-1:0]  i_dp_mul,
    input  logic             i_dp_val
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE_RST,
        S_LOAD,
        S_RUN,
        S_POST_RST
    } state_t;

    localparam int RC_W = $clog2(RST_CYC + 1);
    localparam int WD_W = $clog2(WDOG_CYC + 1);

    localparam logic [RC_W-1:0] RC_PRE_LAST  = RC_W'(RST_CYC - 1);
    localparam logic [RC_W-1:0] RC_POST_LAST = RC_W'(RST_CYC);
    localparam logic [WD_W-1:0] WD_LAST      = WD_W'(WDOG_CYC - 1);

    state_t           state_q, state_d;
    logic [RC_W-1:0]  rc_q, rc_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [SQ_W-1:0]  sq_q, sq_d;
    logic [T_LEN-1:0] t_q, t_d;
    logic [T_LEN-1:0] cnt_q, cnt_d;
    logic [SQ_W-1:0]  res_q, res_d;
    logic             res_val_q, res_val_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             dp_rst_q, dp_rst_d;
    logic             dp_val_q, dp_val_d;
    logic [SQ_W-1:0]  dp_sq_q, dp_sq_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d   = state_q;
        rc_d      = rc_q;
        wd_d      = wd_q;
        sq_d      = sq_q;
        t_d       = t_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        res_val_d = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    cnt_d = '0;
                    if (i_t == '0) begin
                        res_d     = i_sq;
                        res_val_d = 1'b1;
                    end else begin
                        sq_d    = i_sq;
                        t_d     = i_t;
                        rc_d    = '0;
                        state_d = S_PRE_RST;
                    end
                end
            end

            S_PRE_RST: begin
                rc_d = rc_q + RC_W'(1);
                if (i_abort) begin
                    rc_d    = '0;
                    state_d = S_POST_RST;
                end else if (rc_q == RC_PRE_LAST) begin
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                wd_d = '0;
                if (i_abort) begin
                    rc_d    = '0;
                    state_d = S_POST_RST;
                end else begin
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                // A valid beats both the watchdog and an abort arriving in the same cycle.
                if (i_dp_val) begin
                    cnt_d = cnt_q + T_LEN'(1);
                    wd_d  = '0;
                    if (cnt_d == t_q) begin
                        res_d     = i_dp_mul;
                        res_val_d = 1'b1;
                    end
                end else if (wd_q == WD_LAST && !i_abort) begin
                    err_d = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
                if (res_val_d || err_d || i_abort) begin
                    rc_d    = '0;
                    state_d = S_POST_RST;
                end
            end

            S_POST_RST: begin
                rc_d = rc_q + RC_W'(1);
                if (rc_q == RC_POST_LAST) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d   = (state_d != S_IDLE);
        dp_val_d = (state_d == S_LOAD);
        dp_sq_d  = dp_val_d ? sq_d : '0;
        // The first POST_RST cycle carries the result/error pulse; the flush starts one cycle later.
        dp_rst_d = (state_d == S_PRE_RST) || (state_q == S_POST_RST && state_d == S_POST_RST);
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (i_rst) begin
            state_q   <= S_IDLE;
            rc_q      <= '0;
            wd_q      <= '0;
            cnt_q     <= '0;
            res_q     <= '0;
            res_val_q <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            dp_rst_q  <= 1'b0;
            dp_val_q  <= 1'b0;
            dp_sq_q   <= '0;
        end else begin
            state_q   <= state_d;
            rc_q      <= rc_d;
            wd_q      <= wd_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            res_val_q <= res_val_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            dp_rst_q  <= dp_rst_d;
            dp_val_q  <= dp_val_d;
            dp_sq_q   <= dp_sq_d;
        end
    end

    // NOTE: job operands are always written on acceptance before any use, so they carry no reset.
    always_ff @(posedge i_clk) begin
        sq_q <= sq_d;
        t_q  <= t_d;
    end

    assign o_busy    = busy_q;
    assign o_res     = res_q;
    assign o_res_val = res_val_q;
    assign o_err     = err_q;
    assign o_cnt     = cnt_q;
    assign o_dp_rst  = dp_rst_q | i_rst;
    assign o_dp_sq   = dp_sq_q;
    assign o_dp_val  = dp_val_q;

endmodule

// File: doc/redun_mont_seq.md
# redun_mont_seq

Sequencer that runs one VDF squaring job on the `redun_mont` datapath.
- Accepts a Montgomery-form starting value in redundant form (`redun0_t`) and an iteration count t.
- Flushes the datapath, issues a single load, counts the squarings the datapath produces, and captures the t-th result.
- Flushes the datapath again and returns to idle.
- Sits between the host/shell control logic and `redun_mont`. It owns that instance's reset and input ports.

## Interface
Parameters:
- `RST_CYC`, default 4: cycles `o_dp_rst` is held high in each flush phase (≥1).
- `WDOG_CYC`, default 1024: cycles allowed in RUN between datapath output valids before an error.
- `T_LEN`, default `redun_mont_pkg::T_LEN`: iteration-count width.

Ports:
- `i_clk`, in, 1: single clock.
- `i_rst`, in, 1: reset, synchronous, active-high.
- `i_start`, in, 1: job request; sampled only in IDLE.
- `i_sq`, in, `redun0_t`: starting value; sampled with `i_start`.
- `i_t`, in, `T_LEN`: number of squarings; sampled with `i_start`.
- `i_abort`, in, 1: abandon the current job.
- `o_busy`, out, 1: high in every state except IDLE.
- `o_res`, out, `redun0_t`: captured result; holds until the next capture.
- `o_res_val`, out, 1: one-cycle pulse when `o_res` updates.
- `o_err`, out, 1: one-cycle pulse on watchdog expiry.
- `o_cnt`, out, `T_LEN`: squarings received in the current/last job.
- `o_dp_rst`, out, 1: reset to `redun_mont`.
- `o_dp_sq`, out, `redun0_t`: to `redun_mont.i_sq`.
- `o_dp_val`, out, 1: to `redun_mont.i_val`.
- `i_dp_mul`, in, `redun0_t`: from `redun_mont.o_mul`.
- `i_dp_val`, in, 1: from `redun_mont.o_val`.

## Operation
- States: IDLE, PRE_RST, LOAD, RUN, POST_RST.
- IDLE:
  - `i_start` with `i_t`≠0: latch `i_sq` and `i_t`, clear `o_cnt`, go to PRE_RST.
  - `i_start` with `i_t`=0: `o_res`←`i_sq`, pulse `o_res_val` next cycle, `o_cnt`←0, stay in IDLE. The datapath is not touched.
- PRE_RST: `o_dp_rst`=1 for `RST_CYC` cycles, then go to LOAD.
- LOAD: exactly one cycle with `o_dp_val`=1 and `o_dp_sq`=latched start value, then go to RUN. `o_dp_sq`=0 in every other cycle.
- RUN:
  - Each `i_dp_val` increments `o_cnt` and reloads the watchdog counter.
  - When the increment makes `o_cnt`==t: `o_res`←`i_dp_mul`, pulse `o_res_val`, go to POST_RST.
  - The datapath self-iterates. The sequencer never re-drives `o_dp_val` in RUN.
- Watchdog: counts RUN cycles since LOAD or since the last `i_dp_val`. On reaching `WDOG_CYC`: pulse `o_err`, go to POST_RST, `o_res` unchanged.
- POST_RST: `o_dp_rst`=1 for `RST_CYC` cycles, then go to IDLE.
- `i_abort` in PRE_RST/LOAD/RUN: go to POST_RST next cycle. No `o_res_val`, no `o_err`.
- `i_abort` in IDLE or POST_RST: ignored. POST_RST is never restarted.
- `i_dp_val` outside RUN: ignored, no count.
- `i_start` while busy: ignored, not queued.
- Simultaneous events:
  - Final `i_dp_val` and `i_abort` in the same cycle: completion wins. The result is captured and `o_res_val` pulses.
  - Watchdog expiry and `i_dp_val` in the same cycle: the valid wins and the watchdog reloads.
- `o_cnt` does not wrap. t is at most 2^T_LEN−1, so a job ends at or before saturation.

## Timing
- All outputs are registered, except `o_dp_rst` = state-reg OR `i_rst`.
- Reset values:
  - 0: `o_busy`, `o_res`, `o_res_val`, `o_err`, `o_cnt`, `o_dp_val`, `o_dp_sq`.
  - `o_dp_rst`: 1 while `i_rst` is high.
  - State: IDLE.
- Reset mid-job: all job state is discarded. No `o_res_val` or `o_err` follows.
- `i_start` in cycle 0 (t≠0):
  - `o_busy` rises cycle 1.
  - `o_dp_rst` high cycles 1..`RST_CYC`.
  - `o_dp_val` pulses cycle `RST_CYC`+1.
- t=0: `o_res_val` pulses cycle 1. `o_busy` stays 0.
- `o_res_val`/`o_err`: pulse the cycle after the triggering event is sampled. `o_busy` stays high through that cycle.
- Completion: `o_dp_rst` high for the `RST_CYC` cycles after the `o_res_val` cycle. `o_busy` falls the cycle after the last `o_dp_rst`. A new `i_start` is accepted in that cycle.
- Job duration = 2·`RST_CYC` + 2 + datapath time for t squarings.

## Test plan
Bench uses `RST_CYC`=2 and `WDOG_CYC`=64; scenarios 1–4 and 6 instantiate the real `redun_mont`.
- **Normal job:** start=to_redun(to_mont(3)), t=5 → exactly one `o_dp_val` pulse and one `o_res_val` pulse; from_mont(from_redun(`o_res`))==3^(2^5) mod P; `o_cnt`=5; `o_busy` low 3 cycles after `o_res_val`.
- **t=0:** `i_sq`=to_redun(to_mont(7)), t=0 → `o_res_val` in cycle 1; `o_res`==`i_sq`; `o_dp_val` and `o_dp_rst` never assert.
- **Start while busy:** job t=4, then `i_start` with a different value/t=9 mid-RUN → second request ignored; single result matches the t=4 job; `o_cnt`=4.
- **Abort:** t=10 job, `i_abort` when `o_cnt`=3 → no `o_res_val`; `o_dp_rst` high 2 cycles; `o_busy` falls. Next job t=2 returns the correct value with no stale valids counted.
- **Watchdog:** stub datapath that never asserts `i_dp_val` → `o_err` pulses exactly 65 cycles after the LOAD cycle; POST_RST follows, then IDLE.
- **Reset mid-RUN:** `i_rst` high 3 cycles during RUN → all outputs at reset values next cycle; `o_dp_rst`=1 throughout `i_rst`; no later `o_res_val`. A fresh job t=3 is correct.
